// File: rtl/dallanma_cozum_kuyrugu.sv
`default_nettype none
// ============================================================================
// Module   : dallanma_cozum_kuyrugu
// Purpose  : In-order tracking queue between fetch and execute. Each predicted
//            control-flow instruction is held here until execute resolves it.
//            The resolve result drives the predictor update port. When the
//            prediction was wrong, the queue also issues a fetch redirect.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DERINLIK   queue entries (power of two, 2..16)
//   ADRES_W    address / instruction width
// Ports
//   clk_g, rst_g               clock (rising edge), async active-low reset
//   i_ekle_*                   push side: valid, instruction, address,
//                              predicted taken, predicted target, compressed
//   o_dolu / o_bos             full (fetch must stall) / empty
//   i_coz_*                    resolve side: valid, actual taken, actual target
//   i_temizle                  flush; highest priority
//   guncelle_gecerli_g         predictor update strobe (1-cycle pulse)
//   o_eski_buyruk[_adresi]     resolved instruction / address
//   o_buyruk_atladi            actual outcome
//   o_atlanan_adres            actual target
//   o_ongoru_yanlis            misprediction flag
//   o_yonlendir[_adres]        fetch redirect pulse / correct next PC
//   o_hata                     sticky: resolve while empty or push while full
// Configuration
//   DALLANMA_ISTATISTIK_EN     adds saturating counters o_toplam_cozum and
//                              o_yanlis_sayisi
// ============================================================================
module dallanma_cozum_kuyrugu #(
  parameter int DERINLIK = 4,
  parameter int ADRES_W  = 32
) (
  input  logic               clk_g,
  input  logic               rst_g,
  input  logic               i_ekle_gecerli,
  input  logic [ADRES_W-1:0] i_ekle_buyruk,
  input  logic [ADRES_W-1:0] i_ekle_adres,
  input  logic               i_ekle_ongoru,
  input  logic [ADRES_W-1:0] i_ekle_hedef,
  input  logic               i_ekle_comp,
  output logic               o_dolu,
  output logic               o_bos,
  input  logic               i_coz_gecerli,
  input  logic               i_coz_atladi,
  input  logic [ADRES_W-1:0] i_coz_hedef,
  input  logic               i_temizle,
  output logic               guncelle_gecerli_g,
  output logic [ADRES_W-1:0] o_eski_buyruk,
  output logic [ADRES_W-1:0] o_eski_buyruk_adresi,
  output logic               o_buyruk_atladi,
  output logic [ADRES_W-1:0] o_atlanan_adres,
  output logic               o_ongoru_yanlis,
  output logic               o_yonlendir,
  output logic [ADRES_W-1:0] o_yonlendir_adres,
  output logic               o_hata
`ifdef DALLANMA_ISTATISTIK_EN
  ,
  output logic [31:0]        o_toplam_cozum,
  output logic [31:0]        o_yanlis_sayisi
`endif
);

  localparam int PTR_W = $clog2(DERINLIK);
  localparam int CNT_W = $clog2(DERINLIK + 1);

  localparam logic [PTR_W-1:0]   c_ptr_bir  = PTR_W'(1);
  localparam logic [CNT_W-1:0]   c_cnt_bir  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_cnt_dolu = CNT_W'(DERINLIK);
  localparam logic [ADRES_W-1:0] c_adim_2   = ADRES_W'(2);
  localparam logic [ADRES_W-1:0] c_adim_4   = ADRES_W'(4);

  // Entry storage. Only valid slots are ever read, so no reset is needed.
  logic [ADRES_W-1:0] r_buyruk [DERINLIK];
  logic [ADRES_W-1:0] r_adres  [DERINLIK];
  logic [ADRES_W-1:0] r_hedef  [DERINLIK];
  logic               r_ongoru [DERINLIK];
  logic               r_comp   [DERINLIK];

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               r_guncelle;
  logic [ADRES_W-1:0] r_eski_buyruk;
  logic [ADRES_W-1:0] r_eski_adres;
  logic               r_atladi;
  logic [ADRES_W-1:0] r_atlanan;
  logic               r_yanlis;
  logic               r_yonlendir;
  logic [ADRES_W-1:0] r_yon_adres;
  logic               r_hata;

  logic               w_bos;
  logic               w_dolu;
  logic               w_coz_kabul;
  logic               w_coz_hata;
  logic               w_yanlis;
  logic               w_bosalt;
  logic               w_ekle_aday;
  logic               w_ekle_kabul;
  logic               w_ekle_hata;
  logic [ADRES_W-1:0] w_sirali_pc;
  logic [ADRES_W-1:0] w_yon_adres;

  assign w_bos  = (r_count == '0);
  assign w_dolu = (r_count == c_cnt_dolu);

  // A flush cancels every other request in the same cycle.
  assign w_coz_kabul = i_coz_gecerli & ~w_bos & ~i_temizle;
  assign w_coz_hata  = i_coz_gecerli &  w_bos & ~i_temizle;

  assign w_yanlis = (r_ongoru[r_rd_ptr] != i_coz_atladi) |
                    (i_coz_atladi & r_ongoru[r_rd_ptr] &
                     (r_hedef[r_rd_ptr] != i_coz_hedef));

  // A misprediction makes every younger entry wrong-path.
  // The queue is dropped entirely in that case.
  assign w_bosalt = i_temizle | (w_coz_kabul & w_yanlis);

  // Pushes that are cancelled by a flush or a misprediction are silently
  // discarded. Only a genuine overflow is reported as an error.
  assign w_ekle_aday  = i_ekle_gecerli & ~w_bosalt;
  assign w_ekle_kabul = w_ekle_aday & (~w_dolu | w_coz_kabul);
  assign w_ekle_hata  = w_ekle_aday &   w_dolu & ~w_coz_kabul;

  assign w_sirali_pc = r_adres[r_rd_ptr] + (r_comp[r_rd_ptr] ? c_adim_2 : c_adim_4);
  assign w_yon_adres = i_coz_atladi ? i_coz_hedef : w_sirali_pc;

  always_ff @(posedge clk_g) begin
    if (w_ekle_kabul) begin
      r_buyruk[r_wr_ptr] <= i_ekle_buyruk;
      r_adres[r_wr_ptr]  <= i_ekle_adres;
      r_hedef[r_wr_ptr]  <= i_ekle_hedef;
      r_ongoru[r_wr_ptr] <= i_ekle_ongoru;
      r_comp[r_wr_ptr]   <= i_ekle_comp;
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_bosalt) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_coz_kabul) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_bir;
      end
      if (w_ekle_kabul) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_bir;
      end
      case ({w_ekle_kabul, w_coz_kabul})
        2'b10:   r_count <= r_count + c_cnt_bir;
        2'b01:   r_count <= r_count - c_cnt_bir;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_guncelle    <= 1'b0;
      r_yonlendir   <= 1'b0;
      r_eski_buyruk <= '0;
      r_eski_adres  <= '0;
      r_atladi      <= 1'b0;
      r_atlanan     <= '0;
      r_yanlis      <= 1'b0;
      r_yon_adres   <= '0;
      r_hata        <= 1'b0;
    end else begin
      r_guncelle  <= w_coz_kabul;
      r_yonlendir <= w_coz_kabul & w_yanlis;
      // Data outputs hold their values until the next accepted resolve.
      if (w_coz_kabul) begin
        r_eski_buyruk <= r_buyruk[r_rd_ptr];
        r_eski_adres  <= r_adres[r_rd_ptr];
        r_atladi      <= i_coz_atladi;
        r_atlanan     <= i_coz_hedef;
        r_yanlis      <= w_yanlis;
        r_yon_adres   <= w_yon_adres;
      end
      if (w_ekle_hata | w_coz_hata) begin
        r_hata <= 1'b1;
      end
    end
  end

  assign o_dolu               = w_dolu;
  assign o_bos                = w_bos;
  assign guncelle_gecerli_g   = r_guncelle;
  assign o_eski_buyruk        = r_eski_buyruk;
  assign o_eski_buyruk_adresi = r_eski_adres;
  assign o_buyruk_atladi      = r_atladi;
  assign o_atlanan_adres      = r_atlanan;
  assign o_ongoru_yanlis      = r_yanlis;
  assign o_yonlendir          = r_yonlendir;
  assign o_yonlendir_adres    = r_yon_adres;
  assign o_hata               = r_hata;

`ifdef DALLANMA_ISTATISTIK_EN
  logic [31:0] r_toplam;
  logic [31:0] r_yanlis_say;

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_toplam     <= '0;
      r_yanlis_say <= '0;
    end else begin
      if (w_coz_kabul && (r_toplam != 32'hFFFF_FFFF)) begin
        r_toplam <= r_toplam + 32'd1;
      end
      if (w_coz_kabul && w_yanlis && (r_yanlis_say != 32'hFFFF_FFFF)) begin
        r_yanlis_say <= r_yanlis_say + 32'd1;
      end
    end
  end

  assign o_toplam_cozum  = r_toplam;
  assign o_yanlis_sayisi = r_yanlis_say;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dallanma_cozum_kuyrugu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dallanma_cozum_kuyrugu
// Purpose  : Self-checking bench for dallanma_cozum_kuyrugu. It runs three
//            kinds of stimulus: table vectors, hand-written multi-cycle
//            sequences, and random traffic. A queue-based reference model
//            supplies the expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dallanma_cozum_kuyrugu;

  localparam int DER = 4;
  localparam int AW  = 32;

  logic          clk_g = 1'b0;
  logic          rst_g;
  logic          i_ekle_gecerli, i_ekle_ongoru, i_ekle_comp;
  logic [AW-1:0] i_ekle_buyruk, i_ekle_adres, i_ekle_hedef;
  logic          o_dolu, o_bos;
  logic          i_coz_gecerli, i_coz_atladi, i_temizle;
  logic [AW-1:0] i_coz_hedef;
  logic          guncelle_gecerli_g;
  logic [AW-1:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres, o_yonlendir_adres;
  logic          o_buyruk_atladi, o_ongoru_yanlis, o_yonlendir, o_hata;
`ifdef DALLANMA_ISTATISTIK_EN
  logic [31:0]   o_toplam_cozum, o_yanlis_sayisi;
`endif

  dallanma_cozum_kuyrugu #(.DERINLIK(DER), .ADRES_W(AW)) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .i_ekle_gecerli(i_ekle_gecerli), .i_ekle_buyruk(i_ekle_buyruk),
    .i_ekle_adres(i_ekle_adres), .i_ekle_ongoru(i_ekle_ongoru),
    .i_ekle_hedef(i_ekle_hedef), .i_ekle_comp(i_ekle_comp),
    .o_dolu(o_dolu), .o_bos(o_bos),
    .i_coz_gecerli(i_coz_gecerli), .i_coz_atladi(i_coz_atladi),
    .i_coz_hedef(i_coz_hedef), .i_temizle(i_temizle),
    .guncelle_gecerli_g(guncelle_gecerli_g), .o_eski_buyruk(o_eski_buyruk),
    .o_eski_buyruk_adresi(o_eski_buyruk_adresi), .o_buyruk_atladi(o_buyruk_atladi),
    .o_atlanan_adres(o_atlanan_adres), .o_ongoru_yanlis(o_ongoru_yanlis),
    .o_yonlendir(o_yonlendir), .o_yonlendir_adres(o_yonlendir_adres),
    .o_hata(o_hata)
`ifdef DALLANMA_ISTATISTIK_EN
    , .o_toplam_cozum(o_toplam_cozum), .o_yanlis_sayisi(o_yanlis_sayisi)
`endif
  );

  always #5 clk_g = ~clk_g;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    n_chk++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic chkb(input string ad, input logic gercek, input logic beklenen);
    n_chk++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: actual=%0b required=%0b (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  // ---------------- reference model (queue of pending predictions) --------
  typedef struct {
    logic [31:0] buyruk;
    logic [31:0] adres;
    logic [31:0] hedef;
    logic        ongoru;
    logic        comp;
  } ent_t;

  ent_t        q[$];
  logic        m_hata, m_gunc, m_yon, m_yanlis, m_atladi;
  logic [31:0] m_eb, m_ea, m_aa, m_ya, m_toplam, m_ysay;

  function automatic logic [31:0] buyruk_of(input logic [31:0] adres);
    return adres ^ 32'h5A5A_0000;
  endfunction

  task automatic model_sifirla();
    q.delete();
    m_hata = 1'b0; m_gunc = 1'b0; m_yon = 1'b0; m_yanlis = 1'b0; m_atladi = 1'b0;
    m_eb = '0; m_ea = '0; m_aa = '0; m_ya = '0; m_toplam = '0; m_ysay = '0;
  endtask

  task automatic model_adim(input logic ekle, input logic [31:0] adres, input logic ongoru,
                            input logic [31:0] hedef, input logic comp, input logic coz,
                            input logic atladi, input logic [31:0] chedef, input logic temizle);
    ent_t e;
    logic miss;
    m_gunc = 1'b0;
    m_yon  = 1'b0;
    miss   = 1'b0;
    if (temizle) begin
      q.delete();
      return;
    end
    if (coz && q.size() == 0) m_hata = 1'b1;
    if (coz && q.size() > 0) begin
      e = q.pop_front();
      miss = (e.ongoru != atladi) || (atladi && (e.hedef != chedef));
      m_gunc = 1'b1; m_yon = miss; m_yanlis = miss; m_atladi = atladi;
      m_eb = e.buyruk; m_ea = e.adres; m_aa = chedef;
      m_ya = atladi ? chedef : e.adres + (e.comp ? 32'd2 : 32'd4);
      if (m_toplam != 32'hFFFF_FFFF) m_toplam = m_toplam + 32'd1;
      if (miss && m_ysay != 32'hFFFF_FFFF) m_ysay = m_ysay + 32'd1;
    end
    if (miss) begin
      q.delete();
    end else if (ekle) begin
      if (q.size() < DER) begin
        e.buyruk = buyruk_of(adres); e.adres = adres; e.hedef = hedef;
        e.ongoru = ongoru; e.comp = comp;
        q.push_back(e);
      end else begin
        m_hata = 1'b1;
      end
    end
  endtask

  task automatic model_kontrol();
    chkb("bos", o_bos, q.size() == 0);
    chkb("dolu", o_dolu, q.size() == DER);
    chkb("guncelle", guncelle_gecerli_g, m_gunc);
    chkb("yonlendir", o_yonlendir, m_yon);
    chkb("hata", o_hata, m_hata);
    chkb("yanlis", o_ongoru_yanlis, m_yanlis);
    chkb("atladi", o_buyruk_atladi, m_atladi);
    chk("eski_buyruk", o_eski_buyruk, m_eb);
    chk("eski_adres", o_eski_buyruk_adresi, m_ea);
    chk("atlanan_adres", o_atlanan_adres, m_aa);
    chk("yonlendir_adres", o_yonlendir_adres, m_ya);
`ifdef DALLANMA_ISTATISTIK_EN
    chk("toplam_cozum", o_toplam_cozum, m_toplam);
    chk("yanlis_sayisi", o_yanlis_sayisi, m_ysay);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic cycle(input logic ekle, input logic [31:0] adres, input logic ongoru,
                       input logic [31:0] hedef, input logic comp, input logic coz,
                       input logic atladi, input logic [31:0] chedef, input logic temizle);
    i_ekle_gecerli = ekle; i_ekle_adres = adres; i_ekle_buyruk = buyruk_of(adres);
    i_ekle_ongoru = ongoru; i_ekle_hedef = hedef; i_ekle_comp = comp;
    i_coz_gecerli = coz; i_coz_atladi = atladi; i_coz_hedef = chedef; i_temizle = temizle;
    model_adim(ekle, adres, ongoru, hedef, comp, coz, atladi, chedef, temizle);
    @(posedge clk_g);
    #1;
    model_kontrol();
  endtask

  task automatic bosta();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic sifirla();
    rst_g = 1'b0;
    i_ekle_gecerli = 1'b0; i_ekle_adres = '0; i_ekle_buyruk = '0; i_ekle_ongoru = 1'b0;
    i_ekle_hedef = '0; i_ekle_comp = 1'b0; i_coz_gecerli = 1'b0; i_coz_atladi = 1'b0;
    i_coz_hedef = '0; i_temizle = 1'b0;
    model_sifirla();
    @(posedge clk_g);
    #1;
    rst_g = 1'b1;
  endtask

  // ---------------- table vectors ----------------------------------------
  typedef struct {
    logic        ekle;
    logic [31:0] adres;
    logic        ongoru;
    logic [31:0] hedef;
    logic        comp;
    logic        coz;
    logic        atladi;
    logic [31:0] chedef;
    logic        e_gunc;
    logic        e_yon;
    logic        e_yanlis;
    logic [31:0] e_eadr;
    logic [31:0] e_yadr;
    logic        e_bos;
    logic        chk_data;
  } vec_t;

  vec_t vt[9];

  initial begin
    // correct taken
    vt[0] = '{1'b1, 32'h00A0, 1'b1, 32'h0100, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0100,
              1'b1, 1'b0, 1'b0, 32'h00A0, 32'h0100, 1'b1, 1'b1};
    // direction miss on a compressed branch with two younger entries
    vt[2] = '{1'b1, 32'h0040, 1'b1, 32'h0080, 1'b1, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h0050, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h0054, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,
              1'b1, 1'b1, 1'b1, 32'h0040, 32'h0042, 1'b1, 1'b1};
    // target miss
    vt[6] = '{1'b1, 32'h0060, 1'b1, 32'h0200, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0300,
              1'b1, 1'b1, 1'b1, 32'h0060, 32'h0300, 1'b1, 1'b1};
    // idle: pulses drop, data holds
    vt[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              1'b0, 1'b0, 1'b1, 32'h0060, 32'h0300, 1'b1, 1'b1};
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    sifirla();
    chkb("reset_bos", o_bos, 1'b1);
    chkb("reset_dolu", o_dolu, 1'b0);
    chkb("reset_hata", o_hata, 1'b0);

    // Reset in the middle of traffic, while the update pulse is high.
    cycle(1'b1, 32'h0800, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0804, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    rst_g = 1'b0;
    #1;
    chkb("async_rst_bos", o_bos, 1'b1);
    chkb("async_rst_dolu", o_dolu, 1'b0);
    chkb("async_rst_guncelle", guncelle_gecerli_g, 1'b0);
    chkb("async_rst_yonlendir", o_yonlendir, 1'b0);
    sifirla();

    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].ekle, vt[i].adres, vt[i].ongoru, vt[i].hedef, vt[i].comp,
            vt[i].coz, vt[i].atladi, vt[i].chedef, 1'b0);
      chkb($sformatf("vec%0d_guncelle", i), guncelle_gecerli_g, vt[i].e_gunc);
      chkb($sformatf("vec%0d_yonlendir", i), o_yonlendir, vt[i].e_yon);
      chkb($sformatf("vec%0d_bos", i), o_bos, vt[i].e_bos);
      if (vt[i].chk_data) begin
        chkb($sformatf("vec%0d_yanlis", i), o_ongoru_yanlis, vt[i].e_yanlis);
        chk($sformatf("vec%0d_eski_adres", i), o_eski_buyruk_adresi, vt[i].e_eadr);
        chk($sformatf("vec%0d_yon_adres", i), o_yonlendir_adres, vt[i].e_yadr);
      end
    end

    // Full / overflow / wrap-around.
    sifirla();
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 32'h1000 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chkb("full_dolu", o_dolu, 1'b1);
    cycle(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chkb("overflow_hata", o_hata, 1'b1);
    chkb("overflow_dolu", o_dolu, 1'b1);
    cycle(1'b1, 32'h1010, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chkb("full_push_resolve_dolu", o_dolu, 1'b1);
    chk("full_push_resolve_adres", o_eski_buyruk_adresi, 32'h1000);
    for (int j = 1; j <= 8; j++) begin
      cycle(1'b1, 32'h1010 + 32'(4 * j), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk($sformatf("wrap_order%0d", j), o_eski_buyruk_adresi, 32'h1000 + 32'(4 * j));
    end

    // Flush beats a simultaneous resolve; then resolve on empty.
    sifirla();
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h3000 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3333, 1'b1);
    chkb("flush_guncelle", guncelle_gecerli_g, 1'b0);
    chkb("flush_yonlendir", o_yonlendir, 1'b0);
    chkb("flush_bos", o_bos, 1'b1);
    chkb("flush_no_hata", o_hata, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chkb("empty_resolve_hata", o_hata, 1'b1);
    chkb("empty_resolve_guncelle", guncelle_gecerli_g, 1'b0);

    // Random traffic against the model.
    sifirla();
    for (int i = 0; i < 400; i++) begin
      logic        e, o, c, z, a, t;
      logic [31:0] ad, h, ch;
      e  = ($urandom_range(0, 9) < 6);
      ad = $urandom & 32'h0000_FFFE;
      o  = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 1) == 1);
      h  = 32'h100 * 32'($urandom_range(1, 3));
      z  = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        a  = q[0].ongoru;
        ch = q[0].hedef;
      end else begin
        a  = ($urandom_range(0, 1) == 1);
        ch = 32'h100 * 32'($urandom_range(1, 3));
      end
      t = ($urandom_range(0, 39) == 0);
      cycle(e, ad, o, h, c, z, a, ch, t);
    end
    bosta();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
